// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file with write bypass, opcode decode,
// RAW hazard detection against EXE/MEM, and the ID/EXE pipeline register.
module id_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int PC_W       = 32,
    parameter int CNT_W      = 16,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              if_valid,
    input  logic              wb_en,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              exe_wb_en,
    input  logic [4:0]        exe_dest,
    input  logic              mem_wb_en,
    input  logic [4:0]        mem_dest,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic              hazard_stall,
    output logic              valid_out,
    output logic              wb_en_out,
    output logic [1:0]        mem_sig_out,
    output logic [1:0]        br_type_out,
    output logic [3:0]        exe_cmd_out,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] st_val,
    output logic [4:0]        dest_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              flush_out,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_NOR  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_SLA  = 6'b001001;
    localparam logic [5:0] OP_SLL  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;
    localparam logic [5:0] OP_SRL  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_SUBI = 6'b100001;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic signed [15:0] imm_s;
    logic [DATA_W-1:0]  sext;

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign imm_s  = instruction[15:0];
    assign sext   = DATA_W'(imm_s);

    // Register file; R0 is not stored and always reads zero.
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else if (wb_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wb_dest == 5'(i)) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    // Reads of a register being written this cycle see the incoming data.
    logic [DATA_W-1:0] rs_val, rt_val;

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs == 5'(i)) begin
                rs_val = (wb_en && wb_dest == rs) ? wb_data : regs_q[i];
            end
            if (rt == 5'(i)) begin
                rt_val = (wb_en && wb_dest == rt) ? wb_data : regs_q[i];
            end
        end
    end

    logic       dec_wb, dec_imm, dec_nop;
    logic [1:0] dec_mem, dec_br;
    logic [3:0] dec_cmd;

    always_comb begin
        dec_wb  = 1'b0;
        dec_imm = 1'b0;
        dec_nop = 1'b0;
        dec_mem = 2'b00;
        dec_br  = 2'b00;
        dec_cmd = 4'b0000;
        case (opcode)
            OP_ADD:           dec_wb = 1'b1;
            OP_SUB:  begin dec_wb = 1'b1; dec_cmd = 4'b0010; end
            OP_AND:  begin dec_wb = 1'b1; dec_cmd = 4'b0100; end
            OP_OR:   begin dec_wb = 1'b1; dec_cmd = 4'b0101; end
            OP_NOR:  begin dec_wb = 1'b1; dec_cmd = 4'b0110; end
            OP_XOR:  begin dec_wb = 1'b1; dec_cmd = 4'b0111; end
            OP_SLA,
            OP_SLL:  begin dec_wb = 1'b1; dec_cmd = 4'b1000; end
            OP_SRA:  begin dec_wb = 1'b1; dec_cmd = 4'b1001; end
            OP_SRL:  begin dec_wb = 1'b1; dec_cmd = 4'b1010; end
            OP_ADDI: begin dec_wb = 1'b1; dec_imm = 1'b1; end
            OP_SUBI: begin dec_wb = 1'b1; dec_imm = 1'b1; dec_cmd = 4'b0010; end
            OP_LD:   begin dec_wb = 1'b1; dec_imm = 1'b1; dec_mem = 2'b10; end
            OP_ST:   begin dec_imm = 1'b1; dec_mem = 2'b01; end
            OP_BEZ:  begin dec_imm = 1'b1; dec_br = 2'b01; end
            OP_BNE:  begin dec_imm = 1'b1; dec_br = 2'b10; end
            OP_JMP:  begin dec_imm = 1'b1; dec_br = 2'b11; end
            default:        dec_nop = 1'b1;
        endcase
    end

    // ST and BNE read rt even though they carry an immediate.
    logic use_rs, use_rt, rs_hit, rt_hit, hazard;

    assign use_rs = !dec_nop && (opcode != OP_JMP);
    assign use_rt = !dec_nop && (!dec_imm || opcode == OP_ST || opcode == OP_BNE);
    assign rs_hit = (rs != 5'd0) && ((exe_wb_en && rs == exe_dest) || (mem_wb_en && rs == mem_dest));
    assign rt_hit = (rt != 5'd0) && ((exe_wb_en && rt == exe_dest) || (mem_wb_en && rt == mem_dest));
    assign hazard = if_valid && ((use_rs && rs_hit) || (use_rt && rt_hit));
    assign hazard_stall = hazard && !flush_in;

    logic              valid_d, wb_en_d, flush_d;
    logic              valid_q, wb_en_q, flush_q;
    logic [1:0]        mem_sig_d, br_type_d, mem_sig_q, br_type_q;
    logic [3:0]        exe_cmd_d, exe_cmd_q;
    logic [DATA_W-1:0] val1_d, val2_d, st_val_d, val1_q, val2_q, st_val_q;
    logic [4:0]        dest_d, dest_q;
    logic [PC_W-1:0]   pc_d, pc_q;
    logic [CNT_W-1:0]  stall_count_d, stall_count_q;

    always_comb begin
        valid_d   = valid_q;
        wb_en_d   = wb_en_q;
        mem_sig_d = mem_sig_q;
        br_type_d = br_type_q;
        exe_cmd_d = exe_cmd_q;
        val1_d    = val1_q;
        val2_d    = val2_q;
        st_val_d  = st_val_q;
        dest_d    = dest_q;
        pc_d      = pc_q;
        flush_d   = flush_in;
        if (flush_in || (!stall_in && hazard)) begin
            valid_d   = 1'b0;
            wb_en_d   = 1'b0;
            mem_sig_d = 2'b00;
            br_type_d = 2'b00;
            exe_cmd_d = 4'b0000;
            val1_d    = '0;
            val2_d    = '0;
            st_val_d  = '0;
            dest_d    = '0;
            pc_d      = '0;
        end else if (!stall_in) begin
            valid_d   = if_valid;
            wb_en_d   = if_valid && dec_wb;
            mem_sig_d = if_valid ? dec_mem : 2'b00;
            br_type_d = if_valid ? dec_br : 2'b00;
            exe_cmd_d = if_valid ? dec_cmd : 4'b0000;
            val1_d    = rs_val;
            val2_d    = dec_imm ? sext : rt_val;
            st_val_d  = rt_val;
            dest_d    = dec_imm ? rt : rd;
            pc_d      = pc_in;
        end
        stall_count_d = stall_count_q;
        if ((hazard || stall_in) && !flush_in && stall_count_q != {CNT_W{1'b1}}) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            wb_en_q       <= 1'b0;
            mem_sig_q     <= 2'b00;
            br_type_q     <= 2'b00;
            exe_cmd_q     <= 4'b0000;
            val1_q        <= '0;
            val2_q        <= '0;
            st_val_q      <= '0;
            dest_q        <= '0;
            pc_q          <= '0;
            flush_q       <= 1'b0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            wb_en_q       <= wb_en_d;
            mem_sig_q     <= mem_sig_d;
            br_type_q     <= br_type_d;
            exe_cmd_q     <= exe_cmd_d;
            val1_q        <= val1_d;
            val2_q        <= val2_d;
            st_val_q      <= st_val_d;
            dest_q        <= dest_d;
            pc_q          <= pc_d;
            flush_q       <= flush_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign valid_out   = valid_q;
    assign wb_en_out   = wb_en_q;
    assign mem_sig_out = mem_sig_q;
    assign br_type_out = br_type_q;
    assign exe_cmd_out = exe_cmd_q;
    assign val1        = val1_q;
    assign val2        = val2_q;
    assign st_val      = st_val_q;
    assign dest_out    = dest_q;
    assign pc_out      = pc_q;
    assign flush_out   = flush_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, bypass, hazards, stall/flush,
// counter saturation (second instance with CNT_W=2) and async reset.
module tb_id_stage_pipe;

    logic        clk, rst;
    logic [31:0] instruction, pc_in, wb_data;
    logic        if_valid, wb_en, exe_wb_en, mem_wb_en, stall_in, flush_in;
    logic [4:0]  wb_dest, exe_dest, mem_dest;

    logic        hazard_stall, valid_out, wb_en_out, flush_out;
    logic [1:0]  mem_sig_out, br_type_out;
    logic [3:0]  exe_cmd_out;
    logic [31:0] val1, val2, st_val, pc_out;
    logic [4:0]  dest_out;
    logic [15:0] stall_count;

    logic        c2_hazard_stall, c2_valid_out, c2_wb_en_out, c2_flush_out;
    logic [1:0]  c2_mem_sig_out, c2_br_type_out;
    logic [3:0]  c2_exe_cmd_out;
    logic [31:0] c2_val1, c2_val2, c2_st_val, c2_pc_out;
    logic [4:0]  c2_dest_out;
    logic [1:0]  c2_stall_count;

    int checks = 0;
    int failures = 0;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
        .if_valid(if_valid), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .stall_in(stall_in), .flush_in(flush_in),
        .hazard_stall(hazard_stall), .valid_out(valid_out), .wb_en_out(wb_en_out),
        .mem_sig_out(mem_sig_out), .br_type_out(br_type_out), .exe_cmd_out(exe_cmd_out),
        .val1(val1), .val2(val2), .st_val(st_val), .dest_out(dest_out),
        .pc_out(pc_out), .flush_out(flush_out), .stall_count(stall_count)
    );

    id_stage_pipe #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
        .if_valid(if_valid), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .stall_in(stall_in), .flush_in(flush_in),
        .hazard_stall(c2_hazard_stall), .valid_out(c2_valid_out), .wb_en_out(c2_wb_en_out),
        .mem_sig_out(c2_mem_sig_out), .br_type_out(c2_br_type_out), .exe_cmd_out(c2_exe_cmd_out),
        .val1(c2_val1), .val2(c2_val2), .st_val(c2_st_val), .dest_out(c2_dest_out),
        .pc_out(c2_pc_out), .flush_out(c2_flush_out), .stall_count(c2_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {op, s, t, d, 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    initial begin
        rst = 1'b1;
        instruction = 32'd0; pc_in = 32'd0; if_valid = 1'b0;
        wb_en = 1'b0; wb_dest = 5'd0; wb_data = 32'd0;
        exe_wb_en = 1'b0; exe_dest = 5'd0; mem_wb_en = 1'b0; mem_dest = 5'd0;
        stall_in = 1'b0; flush_in = 1'b0;
        #1;
        check_val("rst_valid", valid_out, 0);
        check_val("rst_count", stall_count, 0);
        check_val("rst_val1", val1, 0);
        step(); step();
        rst = 1'b0;

        // ADD r5 = r3 + r4
        instruction = rtype(6'b000001, 5'd3, 5'd4, 5'd5); pc_in = 32'h100; if_valid = 1'b1;
        step();
        check_val("add_val1", val1, 3);
        check_val("add_val2", val2, 4);
        check_val("add_dest", dest_out, 5);
        check_val("add_wb", wb_en_out, 1);
        check_val("add_cmd", exe_cmd_out, 4'b0000);
        check_val("add_valid", valid_out, 1);
        check_val("add_pc", pc_out, 32'h100);

        // ADDI with negative imm, rs bypassed from same-cycle WB
        instruction = itype(6'b100000, 5'd2, 5'd7, 16'hFFFE);
        wb_en = 1'b1; wb_dest = 5'd2; wb_data = 32'd100;
        step();
        wb_en = 1'b0;
        check_val("addi_val2", val2, 32'hFFFFFFFE);
        check_val("addi_dest", dest_out, 7);
        check_val("addi_bypass", val1, 100);

        // SUB r8 = r6 - r1 with r6 in EXE
        instruction = rtype(6'b000011, 5'd6, 5'd1, 5'd8);
        exe_wb_en = 1'b1; exe_dest = 5'd6;
        #1;
        check_val("sub_hazard", hazard_stall, 1);
        step();
        check_val("sub_bubble_valid", valid_out, 0);
        check_val("sub_bubble_wb", wb_en_out, 0);
        check_val("sub_count", stall_count, 1);
        exe_wb_en = 1'b0;
        #1;
        check_val("sub_nohazard", hazard_stall, 0);
        step();
        check_val("sub_valid", valid_out, 1);
        check_val("sub_cmd", exe_cmd_out, 4'b0010);
        check_val("sub_val1", val1, 6);
        check_val("sub_val2", val2, 1);
        check_val("sub_dest", dest_out, 8);

        // hazard and flush together: flush wins, no stall counted
        exe_wb_en = 1'b1; flush_in = 1'b1;
        #1;
        check_val("flush_hazard_stall", hazard_stall, 0);
        step();
        check_val("flush_valid", valid_out, 0);
        check_val("flush_out", flush_out, 1);
        check_val("flush_count", stall_count, 1);
        check_val("flush_val1", val1, 0);
        exe_wb_en = 1'b0; flush_in = 1'b0;
        step();
        check_val("flush_out_clr", flush_out, 0);
        check_val("post_flush_valid", valid_out, 1);

        // external stall for 3 cycles holds SUB while LD waits
        instruction = itype(6'b100100, 5'd1, 5'd9, 16'd4);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_hold_val1", val1, 6);
            check_val("stall_hold_cmd", exe_cmd_out, 4'b0010);
        end
        check_val("stall_count3", stall_count, 4);
        check_val("c2_saturate", c2_stall_count, 3);
        stall_in = 1'b0;
        step();
        check_val("ld_mem", mem_sig_out, 2'b10);
        check_val("ld_wb", wb_en_out, 1);
        check_val("ld_val1", val1, 1);
        check_val("ld_val2", val2, 4);
        check_val("ld_dest", dest_out, 9);

        // rt hazard against MEM
        instruction = rtype(6'b000001, 5'd1, 5'd9, 5'd2);
        mem_wb_en = 1'b1; mem_dest = 5'd9;
        #1;
        check_val("mem_rt_hazard", hazard_stall, 1);
        step();
        check_val("mem_bubble", valid_out, 0);
        check_val("mem_count", stall_count, 5);
        check_val("c2_still_sat", c2_stall_count, 3);
        mem_wb_en = 1'b0;
        step();
        check_val("mem_issue_val2", val2, 9);

        // R0: write ignored, never a hazard source
        instruction = rtype(6'b000001, 5'd0, 5'd0, 5'd1);
        wb_en = 1'b1; wb_dest = 5'd0; wb_data = 32'd55;
        exe_wb_en = 1'b1; exe_dest = 5'd0;
        #1;
        check_val("r0_nohazard", hazard_stall, 0);
        step();
        check_val("r0_bypass", val1, 0);
        wb_en = 1'b0; exe_wb_en = 1'b0;
        step();
        check_val("r0_read", val1, 0);

        // ST / BNE / JMP / illegal opcode
        instruction = itype(6'b100101, 5'd5, 5'd6, 16'd8);
        step();
        check_val("st_mem", mem_sig_out, 2'b01);
        check_val("st_wb", wb_en_out, 0);
        check_val("st_stval", st_val, 6);
        check_val("st_val2", val2, 8);
        instruction = itype(6'b101001, 5'd3, 5'd4, 16'h0010);
        step();
        check_val("bne_br", br_type_out, 2'b10);
        check_val("bne_val2", val2, 16);
        check_val("bne_stval", st_val, 4);
        instruction = itype(6'b101010, 5'd0, 5'd0, 16'h0020);
        step();
        check_val("jmp_br", br_type_out, 2'b11);
        instruction = rtype(6'b111111, 5'd3, 5'd4, 5'd5);
        step();
        check_val("ill_wb", wb_en_out, 0);
        check_val("ill_br", br_type_out, 0);
        check_val("ill_valid", valid_out, 1);

        // if_valid low forces controls to zero
        instruction = rtype(6'b000001, 5'd3, 5'd4, 5'd5); if_valid = 1'b0;
        step();
        check_val("inv_valid", valid_out, 0);
        check_val("inv_wb", wb_en_out, 0);
        check_val("inv_val1", val1, 3);

        // async reset mid-cycle
        if_valid = 1'b1; flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        step();
        check_val("pre_rst_valid", valid_out, 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_valid", valid_out, 0);
        check_val("arst_val1", val1, 0);
        check_val("arst_count", stall_count, 0);
        check_val("arst_wb", wb_en_out, 0);
        #1 rst = 1'b0;
        instruction = rtype(6'b000001, 5'd2, 5'd4, 5'd5);
        step();
        check_val("arst_reg2", val1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
